// File: rtl/spi_pkg.sv
// Shared constants for the SPI register-bus slave: FSM encoding, command-word
// layout and synchroniser depth.
`timescale 1ns/1ps
package spi_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CMD  = CMD,
    ST_WR   = WR,
    ST_RD   = RD
  } state_e;

  localparam int SYNC_STAGES = 2;
  localparam int WORD_CTR_W  = 6;

  // The rw flag is the MSB of the command word, whatever the word width.
  function automatic int rw_pos(input int data_w);
    return data_w - 1;
  endfunction

  function automatic logic [WORD_CTR_W-1:0] sat_inc(input logic [WORD_CTR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// Register-bus handshake between the SPI slave (bus master side) and the
// register file (bus slave side).
`timescale 1ns/1ps
interface spi_reg_slave_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/spi_pad_sync.sv
// Brings csn/sck/mosi pads into the sys_clk domain and derives sck leading and
// trailing edge pulses for the selected clock polarity.
`timescale 1ns/1ps
module spi_pad_sync
  import spi_pkg::*;
#(
  parameter bit CPOL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic csn_pad,
  input  logic sck_pad,
  input  logic mosi_pad,
  output logic sck_lead,
  output logic sck_trail,
  output logic csn_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] csn_ff;
  logic [SYNC_STAGES-1:0] sck_ff;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic                   sck_dly;
  logic                   sck_rise;
  logic                   sck_fall;

  // csn resets to "selected" so that a CS held low across reset can never
  // look like a fresh assert; the FSM separately waits to see CS high first.
  // NOTE: flops take non-blocking assignments so every stage sees the
  // previous stage's pre-edge value, which is what makes this a shift chain.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      csn_ff  <= '0;
      sck_ff  <= {SYNC_STAGES{CPOL}};
      mosi_ff <= '0;
      sck_dly <= CPOL;
    end else begin
      csn_ff  <= {csn_ff[SYNC_STAGES-2:0], csn_pad};
      sck_ff  <= {sck_ff[SYNC_STAGES-2:0], sck_pad};
      mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi_pad};
      sck_dly <= sck_ff[SYNC_STAGES-1];
    end
  end

  assign sck_rise  = sck_ff[SYNC_STAGES-1] & ~sck_dly;
  assign sck_fall  = ~sck_ff[SYNC_STAGES-1] & sck_dly;
  assign sck_lead  = CPOL ? sck_fall : sck_rise;
  assign sck_trail = CPOL ? sck_rise : sck_fall;
  assign csn_s     = csn_ff[SYNC_STAGES-1];
  assign mosi_s    = mosi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI (CPHA=0) slave bridging {rw, addr} command words plus data words onto a
// strobed register bus. Define SPI_REG_SLAVE_AUTOINC_EN for burst address increment.
`timescale 1ns/1ps
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter bit CPOL   = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  csn_pad,
  input  logic                  sck_pad,
  input  logic                  mosi_pad,
  output logic                  miso_pad,
  output logic                  miso_oe,
  output logic                  xfer_active,
  output logic [WORD_CTR_W-1:0] word_ctr,
  spi_reg_slave_if.master       bus
);

  localparam int RW_BIT = rw_pos(DATA_W);
  localparam int BIT_W  = $clog2(DATA_W);

  logic sck_lead, sck_trail, csn_s, mosi_s;

  spi_pad_sync #(.CPOL(CPOL)) u_pad_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csn_pad   (csn_pad),
    .sck_pad   (sck_pad),
    .mosi_pad  (mosi_pad),
    .sck_lead  (sck_lead),
    .sck_trail (sck_trail),
    .csn_s     (csn_s),
    .mosi_s    (mosi_s)
  );

  state_e            state, state_nxt;
  logic [DATA_W-1:0] rx, tx, rx_nxt, wdata_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, re_q, we_nxt, re_nxt;
  logic              word_done, rd_pend, inc_pend, skip_trail, armed;

  assign rx_nxt    = {rx[DATA_W-2:0], mosi_s};
  assign word_done = sck_lead && (bit_cnt == BIT_W'(DATA_W - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: if (!csn_s && armed) state_nxt = ST_CMD;
      ST_CMD: begin
        if (word_done) begin
          state_nxt = rx_nxt[RW_BIT] ? ST_RD : ST_WR;
          re_nxt    = rx_nxt[RW_BIT];
        end
      end
      ST_WR: we_nxt = word_done;
      ST_RD: re_nxt = word_done;
    endcase
    // A CS release seen together with a completing edge suppresses the strobe.
    if (csn_s) begin
      state_nxt = ST_IDLE;
      we_nxt    = 1'b0;
      re_nxt    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx         <= '0;
      tx         <= '0;
      bit_cnt    <= '0;
      word_ctr   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rd_pend    <= 1'b0;
      inc_pend   <= 1'b0;
      skip_trail <= 1'b0;
      armed      <= 1'b0;
    end else begin
      we_q     <= we_nxt;
      re_q     <= re_nxt;
      rd_pend  <= re_q;
      inc_pend <= 1'b0;
      if (csn_s) armed <= 1'b1;

      if (state_nxt == ST_IDLE) begin
        rx         <= '0;
        tx         <= '0;
        bit_cnt    <= '0;
        rd_pend    <= 1'b0;
        skip_trail <= 1'b0;
      end else if (state == ST_IDLE) begin
        rx       <= '0;
        tx       <= '0;
        bit_cnt  <= '0;
        word_ctr <= '0;
      end else begin
        if (sck_lead) begin
          rx      <= rx_nxt;
          bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
        // The trailing edge right after a word boundary must not shift away
        // the MSB of the freshly loaded read word.
        if (word_done) skip_trail <= 1'b1;
        if (sck_trail) begin
          skip_trail <= 1'b0;
          if (!skip_trail) tx <= {tx[DATA_W-2:0], 1'b0};
        end
        if (rd_pend) tx <= bus.reg_rdata;

        if (state == ST_CMD && word_done) addr_q <= rx_nxt[ADDR_W-1:0];
        if (state == ST_WR && word_done) begin
          wdata_q  <= rx_nxt;
          word_ctr <= sat_inc(word_ctr);
`ifdef SPI_REG_SLAVE_AUTOINC_EN
          inc_pend <= 1'b1;
`endif
        end
        if (state == ST_RD && word_done) begin
          word_ctr <= sat_inc(word_ctr);
`ifdef SPI_REG_SLAVE_AUTOINC_EN
          addr_q <= addr_q + 1'b1;
`endif
        end
        if (inc_pend) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign xfer_active   = (state != ST_IDLE);
  assign miso_oe       = (state != ST_IDLE);
  assign miso_pad      = (state != ST_IDLE) && tx[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: an 8-bit CPOL=0 instance and a 16-bit
// CPOL=1 instance, with register-bus strobes checked against an expectation queue.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int HALF = 50;
`ifdef SPI_REG_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       csn0 = 1'b1, sck0 = 1'b0, mosi0 = 1'b0;
  logic       miso0, oe0, act0;
  logic [5:0] wc0;
  logic       csn1 = 1'b1, sck1 = 1'b1, mosi1 = 1'b0;
  logic       miso1, oe1, act1;
  logic [5:0] wc1;

  spi_reg_slave_if #(.ADDR_W(7),  .DATA_W(8))  bus0 ();
  spi_reg_slave_if #(.ADDR_W(10), .DATA_W(16)) bus1 ();

  spi_reg_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .csn_pad(csn0), .sck_pad(sck0),
    .mosi_pad(mosi0), .miso_pad(miso0), .miso_oe(oe0), .xfer_active(act0),
    .word_ctr(wc0), .bus(bus0)
  );

  spi_reg_slave #(.DATA_W(16), .ADDR_W(10), .CPOL(1'b1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .csn_pad(csn1), .sck_pad(sck1),
    .mosi_pad(mosi1), .miso_pad(miso1), .miso_oe(oe1), .xfer_active(act1),
    .word_ctr(wc1), .bus(bus1)
  );

  // Register-file model: read data is addr + 0x40, registered off reg_re.
  always @(posedge sys_clk) begin
    if (!sys_rst_n)         bus0.reg_rdata <= '0;
    else if (bus0.reg_re)   bus0.reg_rdata <= {1'b0, bus0.reg_addr} + 8'h40;
  end
  assign bus1.reg_rdata = '0;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_wr0[$];
  wr_t         exp_wr1[$];
  logic [15:0] exp_rd0[$];
  logic [15:0] exp_rd1[$];
  logic [15:0] exp_miso[$];
  wr_t         e0, e1;
  logic [15:0] r0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] base, input int k,
                                           input logic [15:0] mask);
    return AUTOINC ? ((base + 16'(k)) & mask) : base;
  endfunction

  always @(negedge sys_clk) begin
    if (bus0.reg_we || bus0.reg_re)
      check("we_re_exclusive0", 32'(bus0.reg_we & bus0.reg_re), 32'd0);
    if (bus0.reg_we) begin
      check("we0_expected", 32'(exp_wr0.size() != 0), 32'd1);
      if (exp_wr0.size() != 0) begin
        e0 = exp_wr0.pop_front();
        check("we0_addr", 32'(bus0.reg_addr), 32'(e0.addr));
        check("we0_wdata", 32'(bus0.reg_wdata), 32'(e0.data));
      end
    end
    if (bus0.reg_re) begin
      check("re0_expected", 32'(exp_rd0.size() != 0), 32'd1);
      if (exp_rd0.size() != 0) begin
        r0 = exp_rd0.pop_front();
        check("re0_addr", 32'(bus0.reg_addr), 32'(r0));
      end
    end
    if (bus1.reg_we) begin
      check("we1_expected", 32'(exp_wr1.size() != 0), 32'd1);
      if (exp_wr1.size() != 0) begin
        e1 = exp_wr1.pop_front();
        check("we1_addr", 32'(bus1.reg_addr), 32'(e1.addr));
        check("we1_wdata", 32'(bus1.reg_wdata), 32'(e1.data));
      end
    end
    if (bus1.reg_re) check("re1_expected", 32'(exp_rd1.size() != 0), 32'd1);
  end

  // CPHA=0 master: data set before the leading edge, MISO sampled on it.
  task automatic spi_bits(input int sel, input logic [15:0] val, input int n,
                          output logic [15:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (sel == 0) mosi0 = val[i]; else mosi1 = val[i];
      #HALF;
      if (sel == 0) begin sck0 = 1'b1; rx = {rx[14:0], miso0}; end
      else          begin sck1 = 1'b0; rx = {rx[14:0], miso1}; end
      #HALF;
      if (sel == 0) sck0 = 1'b0; else sck1 = 1'b1;
    end
  endtask

  task automatic cs_assert(input int sel);
    if (sel == 0) csn0 = 1'b0; else csn1 = 1'b0;
    #100;
  endtask

  task automatic cs_release(input int sel);
    #100;
    if (sel == 0) csn0 = 1'b1; else csn1 = 1'b1;
    #100;
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_miso"}, 32'(miso0), 32'd0);
    check({tag, "_oe"}, 32'(oe0), 32'd0);
    check({tag, "_active"}, 32'(act0), 32'd0);
    check({tag, "_we"}, 32'(bus0.reg_we), 32'd0);
    check({tag, "_re"}, 32'(bus0.reg_re), 32'd0);
  endtask

  logic [15:0] rxw;

  initial begin
    #3;
    #50;
    check_idle0("reset");
    check("reset_addr", 32'(bus0.reg_addr), 32'd0);
    check("reset_wdata", 32'(bus0.reg_wdata), 32'd0);
    check("reset_wctr", 32'(wc0), 32'd0);
    check("reset_active1", 32'(act1), 32'd0);
    sys_rst_n = 1'b1;
    #100;

    // Single write
    exp_wr0.push_back('{addr: 16'h05, data: 16'hA7});
    cs_assert(0);
    check("sel_active", 32'(act0), 32'd1);
    check("sel_oe", 32'(oe0), 32'd1);
    spi_bits(0, 16'h05, 8, rxw);
    spi_bits(0, 16'hA7, 8, rxw);
    cs_release(0);
    check("single_wctr", 32'(wc0), 32'd1);
    check("single_addr", 32'(bus0.reg_addr), 32'(exp_addr(16'h05, 1, 16'h7F)));
    check_idle0("single_end");

    // Write burst with wrap
    exp_wr0.push_back('{addr: exp_addr(16'h7E, 0, 16'h7F), data: 16'h11});
    exp_wr0.push_back('{addr: exp_addr(16'h7E, 1, 16'h7F), data: 16'h22});
    exp_wr0.push_back('{addr: exp_addr(16'h7E, 2, 16'h7F), data: 16'h33});
    cs_assert(0);
    spi_bits(0, 16'h7E, 8, rxw);
    spi_bits(0, 16'h11, 8, rxw);
    spi_bits(0, 16'h22, 8, rxw);
    spi_bits(0, 16'h33, 8, rxw);
    cs_release(0);
    check("burst_wctr", 32'(wc0), 32'd3);
    check("burst_addr", 32'(bus0.reg_addr), 32'(exp_addr(16'h7E, 3, 16'h7F)));

    // Read burst
    for (int k = 0; k < 3; k++) exp_rd0.push_back(exp_addr(16'h03, k, 16'h7F));
    exp_miso.push_back(exp_addr(16'h03, 0, 16'h7F) + 16'h40);
    exp_miso.push_back(exp_addr(16'h03, 1, 16'h7F) + 16'h40);
    cs_assert(0);
    spi_bits(0, 16'h83, 8, rxw);
    spi_bits(0, 16'h00, 8, rxw);
    check("read_miso_w0", 32'(rxw), 32'(exp_miso.pop_front()));
    spi_bits(0, 16'h00, 8, rxw);
    check("read_miso_w1", 32'(rxw), 32'(exp_miso.pop_front()));
    cs_release(0);
    check("read_wctr", 32'(wc0), 32'd2);
    check("read_addr", 32'(bus0.reg_addr), 32'(exp_addr(16'h03, 2, 16'h7F)));
    check_idle0("read_end");

    // Abort after 5 bits of a data word
    cs_assert(0);
    spi_bits(0, 16'h10, 8, rxw);
    spi_bits(0, 16'h15, 5, rxw);
    cs_release(0);
    check_idle0("abort");
    check("abort_addr_hold", 32'(bus0.reg_addr), 32'h10);
    check("abort_wctr", 32'(wc0), 32'd0);
    exp_wr0.push_back('{addr: 16'h20, data: 16'h5A});
    cs_assert(0);
    spi_bits(0, 16'h20, 8, rxw);
    spi_bits(0, 16'h5A, 8, rxw);
    cs_release(0);
    check("post_abort_wctr", 32'(wc0), 32'd1);

    // Reset pulse during bit 3 of a read data word
    exp_rd0.push_back(16'h30);
    cs_assert(0);
    spi_bits(0, 16'hB0, 8, rxw);
    spi_bits(0, 16'h00, 3, rxw);
    @(negedge sys_clk) sys_rst_n = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    #3;
    check_idle0("midreset");
    check("midreset_addr", 32'(bus0.reg_addr), 32'd0);
    check("midreset_wctr", 32'(wc0), 32'd0);
    spi_bits(0, 16'h00, 5, rxw);
    spi_bits(0, 16'hC1, 8, rxw);
    check("midreset_stay_idle", 32'(act0), 32'd0);
    cs_release(0);
    exp_wr0.push_back('{addr: 16'h44, data: 16'h99});
    cs_assert(0);
    spi_bits(0, 16'h44, 8, rxw);
    spi_bits(0, 16'h99, 8, rxw);
    cs_release(0);
    check("post_reset_wctr", 32'(wc0), 32'd1);

    // 16-bit word, CPOL=1 instance
    exp_wr1.push_back('{addr: 16'h123, data: 16'hBEEF});
    cs_assert(1);
    check("wide_active", 32'(act1), 32'd1);
    spi_bits(1, 16'h0123, 16, rxw);
    spi_bits(1, 16'hBEEF, 16, rxw);
    cs_release(1);
    check("wide_wctr", 32'(wc1), 32'd1);
    check("wide_idle", 32'(act1), 32'd0);

    #200;
    check("drain_wr0", 32'(exp_wr0.size()), 32'd0);
    check("drain_rd0", 32'(exp_rd0.size()), 32'd0);
    check("drain_wr1", 32'(exp_wr1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
